// File: rtl/asic_top.sv
// Chip top: pad ring, IP select decode, clock forwarding and the UART-driven
// 2x2 matrix diagonal-sum engine (IP 1).
module asic_top #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic sys_clk_i_pad,
    input  logic rst_n_pad,
    output logic sys_clk_o_pad,
    input  logic ip_sel_pad0,
    input  logic ip_sel_pad1,
    input  logic ip_sel_pad2,
    inout  wire  io_pad0,  io_pad1,  io_pad2,  io_pad3,  io_pad4,  io_pad5,  io_pad6,  io_pad7,
    inout  wire  io_pad8,  io_pad9,  io_pad10, io_pad11, io_pad12, io_pad13, io_pad14, io_pad15,
    inout  wire  io_pad16, io_pad17, io_pad18, io_pad19, io_pad20, io_pad21, io_pad22, io_pad23,
    inout  wire  io_pad24, io_pad25, io_pad26, io_pad27, io_pad28, io_pad29, io_pad30, io_pad31,
    inout  wire  io_pad32, io_pad33, io_pad34, io_pad35, io_pad36, io_pad37, io_pad38, io_pad39,
    inout  wire  io_pad40, io_pad41, io_pad42, io_pad43, io_pad44, io_pad45, io_pad46, io_pad47,
    inout  wire  io_pad48, io_pad49, io_pad50, io_pad51, io_pad52, io_pad53, io_pad54, io_pad55,
    inout  wire  io_pad56, io_pad57, io_pad58, io_pad59, io_pad60, io_pad61, io_pad62, io_pad63,
    inout  wire  io_pad64, io_pad65,
    inout  wire  io_pad66, io_pad67, io_pad68, io_pad69, io_pad70, io_pad71, io_pad72, io_pad73,
    inout  wire  io_pad74, io_pad75, io_pad76, io_pad77, io_pad78, io_pad79, io_pad80, io_pad81
);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic clk;
    logic sel;
    logic core_rst_n;
    logic unused_pads;

    assign clk           = sys_clk_i_pad;
    assign sys_clk_o_pad = sys_clk_i_pad;
    assign sel           = ({ip_sel_pad2, ip_sel_pad1, ip_sel_pad0} == 3'b001);
    // Deselecting the IP wipes the whole core, mid-operation included
    assign core_rst_n    = rst_n_pad & sel;
    assign unused_pads   = ^{io_pad0,  io_pad1,  io_pad2,  io_pad3,  io_pad4,  io_pad5,  io_pad6,  io_pad7,
                             io_pad8,  io_pad9,  io_pad10, io_pad11, io_pad12, io_pad13, io_pad14, io_pad15,
                             io_pad16, io_pad17, io_pad18, io_pad19, io_pad20, io_pad21, io_pad22, io_pad23,
                             io_pad24, io_pad25, io_pad26, io_pad27, io_pad28, io_pad29, io_pad30, io_pad31,
                             io_pad66, io_pad67, io_pad68, io_pad69, io_pad70, io_pad71, io_pad72, io_pad73,
                             io_pad74, io_pad75, io_pad76, io_pad77, io_pad78, io_pad79, io_pad80, io_pad81};

    // UART receiver state
    rx_state_t        rx_state_q, rx_state_d;
    logic             rx_s1_q, rx_s2_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;

    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_s1_q    <= io_pad65;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_valid_d = rx_s2_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Matrix store and diagonal sums
    logic [1:0]  byte_cnt_q;
    logic [7:0]  m0_q, m1_q, m2_q, m3_q;
    logic        load_q;
    logic [31:0] result_q;
    logic [7:0]  diag_a_c, diag_b_c;
    logic [31:0] sums_c;

    assign diag_a_c = m0_q + m3_q;
    assign diag_b_c = m1_q + m2_q;
    assign sums_c   = {diag_b_c, diag_a_c, diag_b_c, diag_a_c};

    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            byte_cnt_q <= '0;
            m0_q       <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            m3_q       <= '0;
            load_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            load_q <= rx_valid_q && (byte_cnt_q == 2'd3);
            if (rx_valid_q) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0:    m0_q <= rx_shift_q;
                    2'd1:    m1_q <= rx_shift_q;
                    2'd2:    m2_q <= rx_shift_q;
                    default: m3_q <= rx_shift_q;
                endcase
            end
            if (load_q) result_q <= sums_c;
        end
    end

    // UART transmitter: four back-to-back frames from a latched copy of the sums
    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [1:0]       tx_byte_q, tx_byte_d;
    logic [31:0]      tx_buf_q, tx_buf_d;
    logic             tx_line_q, tx_line_d;

    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_buf_q   <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_buf_q   <= tx_buf_d;
            tx_line_q  <= tx_line_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_buf_d   = tx_buf_q;
        tx_line_d  = tx_line_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
                if (load_q) begin
                    tx_buf_d   = sums_c;
                    tx_byte_d  = '0;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_line_d  = tx_buf_q[0];
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                tx_buf_d = tx_buf_q >> 1;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) begin
                    tx_line_d  = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_line_d = tx_buf_q[1];
                end
            end
            TX_STOP: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                if (tx_byte_q == 2'd3) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_byte_d  = tx_byte_q + 2'd1;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Pad drivers: result bus and TX only while the matrix IP is selected
    assign io_pad32 = sel ? result_q[0]  : 1'bz;  assign io_pad33 = sel ? result_q[1]  : 1'bz;
    assign io_pad34 = sel ? result_q[2]  : 1'bz;  assign io_pad35 = sel ? result_q[3]  : 1'bz;
    assign io_pad36 = sel ? result_q[4]  : 1'bz;  assign io_pad37 = sel ? result_q[5]  : 1'bz;
    assign io_pad38 = sel ? result_q[6]  : 1'bz;  assign io_pad39 = sel ? result_q[7]  : 1'bz;
    assign io_pad40 = sel ? result_q[8]  : 1'bz;  assign io_pad41 = sel ? result_q[9]  : 1'bz;
    assign io_pad42 = sel ? result_q[10] : 1'bz;  assign io_pad43 = sel ? result_q[11] : 1'bz;
    assign io_pad44 = sel ? result_q[12] : 1'bz;  assign io_pad45 = sel ? result_q[13] : 1'bz;
    assign io_pad46 = sel ? result_q[14] : 1'bz;  assign io_pad47 = sel ? result_q[15] : 1'bz;
    assign io_pad48 = sel ? result_q[16] : 1'bz;  assign io_pad49 = sel ? result_q[17] : 1'bz;
    assign io_pad50 = sel ? result_q[18] : 1'bz;  assign io_pad51 = sel ? result_q[19] : 1'bz;
    assign io_pad52 = sel ? result_q[20] : 1'bz;  assign io_pad53 = sel ? result_q[21] : 1'bz;
    assign io_pad54 = sel ? result_q[22] : 1'bz;  assign io_pad55 = sel ? result_q[23] : 1'bz;
    assign io_pad56 = sel ? result_q[24] : 1'bz;  assign io_pad57 = sel ? result_q[25] : 1'bz;
    assign io_pad58 = sel ? result_q[26] : 1'bz;  assign io_pad59 = sel ? result_q[27] : 1'bz;
    assign io_pad60 = sel ? result_q[28] : 1'bz;  assign io_pad61 = sel ? result_q[29] : 1'bz;
    assign io_pad62 = sel ? result_q[30] : 1'bz;  assign io_pad63 = sel ? result_q[31] : 1'bz;
    assign io_pad64 = sel ? tx_line_q    : 1'bz;

endmodule

// File: tb/tb_asic_top.sv
// Directed bench for asic_top: UART byte groups in, diagonal sums on the pads
// and echoed back over UART TX; framing errors, glitches and IP deselect.
module tb_asic_top;
    localparam int unsigned BAUD   = 115_200;
    localparam int unsigned CLK_HZ = 16 * BAUD;
    localparam int unsigned CPB    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ip_sel;
    logic       rx_line;
    logic       clk_o;
    logic       hz_en;
    logic [32:0] hz_pat;
    logic       mon_en;
    logic [7:0] mon_byte;
    logic [8:0] tx_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;

    wire p0,  p1,  p2,  p3,  p4,  p5,  p6,  p7,  p8,  p9,  p10, p11, p12, p13, p14, p15;
    wire p16, p17, p18, p19, p20, p21, p22, p23, p24, p25, p26, p27, p28, p29, p30, p31;
    wire p32, p33, p34, p35, p36, p37, p38, p39, p40, p41, p42, p43, p44, p45, p46, p47;
    wire p48, p49, p50, p51, p52, p53, p54, p55, p56, p57, p58, p59, p60, p61, p62, p63;
    wire p64, p65, p66, p67, p68, p69, p70, p71, p72, p73, p74, p75, p76, p77, p78, p79;
    wire p80, p81;
    wire [31:0] gpio_obs = {p63, p62, p61, p60, p59, p58, p57, p56, p55, p54, p53, p52, p51, p50, p49, p48,
                            p47, p46, p45, p44, p43, p42, p41, p40, p39, p38, p37, p36, p35, p34, p33, p32};

    always #5 clk = ~clk;

    assign p65 = rx_line;
    // Bench drivers on the DUT-driven pads, enabled only to prove the DUT has let go
    assign p32 = hz_en ? hz_pat[0]  : 1'bz;  assign p33 = hz_en ? hz_pat[1]  : 1'bz;
    assign p34 = hz_en ? hz_pat[2]  : 1'bz;  assign p35 = hz_en ? hz_pat[3]  : 1'bz;
    assign p36 = hz_en ? hz_pat[4]  : 1'bz;  assign p37 = hz_en ? hz_pat[5]  : 1'bz;
    assign p38 = hz_en ? hz_pat[6]  : 1'bz;  assign p39 = hz_en ? hz_pat[7]  : 1'bz;
    assign p40 = hz_en ? hz_pat[8]  : 1'bz;  assign p41 = hz_en ? hz_pat[9]  : 1'bz;
    assign p42 = hz_en ? hz_pat[10] : 1'bz;  assign p43 = hz_en ? hz_pat[11] : 1'bz;
    assign p44 = hz_en ? hz_pat[12] : 1'bz;  assign p45 = hz_en ? hz_pat[13] : 1'bz;
    assign p46 = hz_en ? hz_pat[14] : 1'bz;  assign p47 = hz_en ? hz_pat[15] : 1'bz;
    assign p48 = hz_en ? hz_pat[16] : 1'bz;  assign p49 = hz_en ? hz_pat[17] : 1'bz;
    assign p50 = hz_en ? hz_pat[18] : 1'bz;  assign p51 = hz_en ? hz_pat[19] : 1'bz;
    assign p52 = hz_en ? hz_pat[20] : 1'bz;  assign p53 = hz_en ? hz_pat[21] : 1'bz;
    assign p54 = hz_en ? hz_pat[22] : 1'bz;  assign p55 = hz_en ? hz_pat[23] : 1'bz;
    assign p56 = hz_en ? hz_pat[24] : 1'bz;  assign p57 = hz_en ? hz_pat[25] : 1'bz;
    assign p58 = hz_en ? hz_pat[26] : 1'bz;  assign p59 = hz_en ? hz_pat[27] : 1'bz;
    assign p60 = hz_en ? hz_pat[28] : 1'bz;  assign p61 = hz_en ? hz_pat[29] : 1'bz;
    assign p62 = hz_en ? hz_pat[30] : 1'bz;  assign p63 = hz_en ? hz_pat[31] : 1'bz;
    assign p64 = hz_en ? hz_pat[32] : 1'bz;

    asic_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .sys_clk_i_pad(clk), .rst_n_pad(rst_n), .sys_clk_o_pad(clk_o),
        .ip_sel_pad0(ip_sel[0]), .ip_sel_pad1(ip_sel[1]), .ip_sel_pad2(ip_sel[2]),
        .io_pad0(p0),   .io_pad1(p1),   .io_pad2(p2),   .io_pad3(p3),   .io_pad4(p4),   .io_pad5(p5),
        .io_pad6(p6),   .io_pad7(p7),   .io_pad8(p8),   .io_pad9(p9),   .io_pad10(p10), .io_pad11(p11),
        .io_pad12(p12), .io_pad13(p13), .io_pad14(p14), .io_pad15(p15), .io_pad16(p16), .io_pad17(p17),
        .io_pad18(p18), .io_pad19(p19), .io_pad20(p20), .io_pad21(p21), .io_pad22(p22), .io_pad23(p23),
        .io_pad24(p24), .io_pad25(p25), .io_pad26(p26), .io_pad27(p27), .io_pad28(p28), .io_pad29(p29),
        .io_pad30(p30), .io_pad31(p31), .io_pad32(p32), .io_pad33(p33), .io_pad34(p34), .io_pad35(p35),
        .io_pad36(p36), .io_pad37(p37), .io_pad38(p38), .io_pad39(p39), .io_pad40(p40), .io_pad41(p41),
        .io_pad42(p42), .io_pad43(p43), .io_pad44(p44), .io_pad45(p45), .io_pad46(p46), .io_pad47(p47),
        .io_pad48(p48), .io_pad49(p49), .io_pad50(p50), .io_pad51(p51), .io_pad52(p52), .io_pad53(p53),
        .io_pad54(p54), .io_pad55(p55), .io_pad56(p56), .io_pad57(p57), .io_pad58(p58), .io_pad59(p59),
        .io_pad60(p60), .io_pad61(p61), .io_pad62(p62), .io_pad63(p63), .io_pad64(p64), .io_pad65(p65),
        .io_pad66(p66), .io_pad67(p67), .io_pad68(p68), .io_pad69(p69), .io_pad70(p70), .io_pad71(p71),
        .io_pad72(p72), .io_pad73(p73), .io_pad74(p74), .io_pad75(p75), .io_pad76(p76), .io_pad77(p77),
        .io_pad78(p78), .io_pad79(p79), .io_pad80(p80), .io_pad81(p81)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame; a bad frame holds stop low past its mid-bit sample
    task automatic uart_send(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (bad_stop) begin
            rx_line = 1'b0;
            repeat (CPB / 2 + 4) @(negedge clk);
            rx_line = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            rx_line = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic send_group(input logic [31:0] bytes);
        for (int i = 0; i < 4; i++) uart_send(bytes[8*i +: 8], 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Expect four echoed frames carrying word[7:0] first, each with a high stop bit
    task automatic check_tx(input string tag, input logic [31:0] word);
        check_eq({tag, "_cnt"}, 32'(tx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq(tag, (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF, {23'd0, 1'b1, word[8*i +: 8]});
        tx_q.delete();
    endtask

    // UART TX monitor: records {stop_bit, data} per frame
    always begin
        @(negedge clk);
        if (mon_en && p64 == 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_byte[i] = p64;
            end
            repeat (CPB) @(negedge clk);
            tx_q.push_back({p64, mon_byte});
        end
    end

    initial begin
        rst_n   = 1'b0;
        ip_sel  = 3'b001;
        rx_line = 1'b1;
        hz_en   = 1'b0;
        hz_pat  = '0;
        mon_en  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_gpio", gpio_obs, 32'h0000_0000);
        check_eq("rst_tx", 32'(p64), 32'd1);
        check_eq("clk_fwd_lo", 32'(clk_o), 32'(clk));
        @(posedge clk);
        #1 check_eq("clk_fwd_hi", 32'(clk_o), 32'(clk));
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        send_group(32'h0403_0201);
        check_eq("grp1_gpio", gpio_obs, 32'h0505_0505);
        repeat (700) @(negedge clk);
        check_tx("grp1_tx", 32'h0505_0505);

        send_group(32'h0220_10FF);
        check_eq("grp2_wrap", gpio_obs, 32'h3001_3001);
        repeat (700) @(negedge clk);
        check_tx("grp2_tx", 32'h3001_3001);

        uart_send(8'h10, 1'b0);
        uart_send(8'h20, 1'b0);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_eq("glitch_hold", gpio_obs, 32'h3001_3001);
        uart_send(8'h03, 1'b0);
        uart_send(8'h77, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("frame_err_hold", gpio_obs, 32'h3001_3001);
        uart_send(8'h05, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("grp3_gpio", gpio_obs, 32'h2315_2315);
        repeat (700) @(negedge clk);
        check_tx("grp3_tx", 32'h2315_2315);

        uart_send(8'hAA, 1'b0);
        mon_en = 1'b0;
        @(negedge clk);
        ip_sel = 3'b010;
        hz_pat = 33'h0_A5C3_5A3C;
        hz_en  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("desel_gpio_hz", gpio_obs, 32'hA5C3_5A3C);
        check_eq("desel_tx_hz", 32'(p64), 32'd0);
        hz_en = 1'b0;
        @(negedge clk);
        ip_sel = 3'b001;
        repeat (2) @(negedge clk);
        check_eq("resel_gpio", gpio_obs, 32'h0000_0000);
        check_eq("resel_tx_idle", 32'(p64), 32'd1);
        mon_en = 1'b1;
        send_group(32'h0403_0201);
        check_eq("resel_grp", gpio_obs, 32'h0505_0505);
        repeat (700) @(negedge clk);
        check_tx("resel_tx", 32'h0505_0505);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
